// File: rtl/gb_cpu_sched_sequencer.sv
// gb_cpu_sched_sequencer
// M-cycle sequencer between the decoder and the datapath. Latches a schedule
// of up to DEPTH control words plus a length, then issues one word per M-cycle
// on ctrl_o. It supports:
//   - stall hold,
//   - condition-fail truncation (jump to the final slot),
//   - chaining of a new schedule onto the final (fetch-overlap) slot with no
//     bubble.
//
// Optional feature (macro GB_SCHED_IRQ_EN): an interrupt-dispatch schedule can
// be injected at any accept point. It takes priority over the decoder.
//
// Ports
//   clk         system clock
//   reset       asynchronous active-high reset
//   mcycle_en   one-clock strobe at each M-cycle boundary
//   stall       hold the current slot; wins over mcycle_en
//   load_valid  decoder presents a new schedule
//   load_ctrl   schedule words, slot k at [k*CTRL_W +: CTRL_W]
//   load_len    M-cycle count of the new schedule (0 -> 1, >DEPTH -> DEPTH)
//   cc_fail     condition of the current slot evaluated false
//   irq_req     (GB_SCHED_IRQ_EN) interrupt dispatch request
//   irq_ctrl    (GB_SCHED_IRQ_EN) dispatch schedule words
//   irq_len     (GB_SCHED_IRQ_EN) dispatch schedule length
//   irq_ack     (GB_SCHED_IRQ_EN) one-clock pulse when dispatch is taken
//   load_ready  decoder schedule accepted on this mcycle_en
//   ctrl_o      registered control word of the current slot
//   slot_o      index of the current slot
//   last_o      current slot is the final (opcode-fetch overlap) slot
//   busy_o      a schedule is running
module gb_cpu_sched_sequencer #(
    parameter int CTRL_W = 64,
    parameter int DEPTH  = 6,
    parameter int LEN_W  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mcycle_en,
    input  logic                    stall,
    input  logic                    load_valid,
    input  logic [DEPTH*CTRL_W-1:0] load_ctrl,
    input  logic [LEN_W-1:0]        load_len,
    input  logic                    cc_fail,
`ifdef GB_SCHED_IRQ_EN
    input  logic                    irq_req,
    input  logic [DEPTH*CTRL_W-1:0] irq_ctrl,
    input  logic [LEN_W-1:0]        irq_len,
    output logic                    irq_ack,
`endif
    output logic                    load_ready,
    output logic [CTRL_W-1:0]       ctrl_o,
    output logic [LEN_W-1:0]        slot_o,
    output logic                    last_o,
    output logic                    busy_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  slot, slot_nxt, len, step_slot, src_len, norm_len;
    logic [CTRL_W-1:0] ctrl_nxt, step_word;
    logic [CTRL_W-1:0] sched [DEPTH];
    logic [DEPTH*CTRL_W-1:0] src_ctrl;
    logic              adv, last, accept_pt, take;

    assign adv       = mcycle_en & ~stall;
    assign last      = (state == RUN) && (slot == len - LEN_W'(1));
    assign accept_pt = adv & ((state == IDLE) | last);

`ifdef GB_SCHED_IRQ_EN
    // A halted (stalled) idle core must still wake up for an interrupt, so the
    // dispatch accept point ignores stall only in IDLE.
    logic irq_pt, irq_take;
    assign irq_pt     = mcycle_en & ((state == IDLE) | (~stall & last));
    assign irq_take   = irq_req & irq_pt;
    assign take       = irq_take | (accept_pt & load_valid);
    assign load_ready = accept_pt & ~irq_take;
    assign src_ctrl   = irq_take ? irq_ctrl : load_ctrl;
    assign src_len    = irq_take ? irq_len  : load_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq_ack <= 1'b0;
        else       irq_ack <= irq_take;
    end
`else
    assign take       = accept_pt & load_valid;
    assign load_ready = accept_pt;
    assign src_ctrl   = load_ctrl;
    assign src_len    = load_len;
`endif

    // A zero length still issues one word; over-long lengths saturate at DEPTH.
    always_comb begin
        norm_len = src_len;
        if (src_len == '0)
            norm_len = LEN_W'(1);
        else if (src_len > LEN_W'(DEPTH))
            norm_len = LEN_W'(DEPTH);
    end

    // A failed condition skips straight to the final slot.
    assign step_slot = cc_fail ? (len - LEN_W'(1)) : (slot + LEN_W'(1));

    always_comb begin
        step_word = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (step_slot == LEN_W'(k))
                step_word = sched[k];
        end
    end

    // Next-state logic.
    // A freshly accepted schedule issues slot 0 straight from the input bus,
    // because the stored copy is only written on the same edge.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        ctrl_nxt  = ctrl_o;
        if (take) begin
            state_nxt = RUN;
            slot_nxt  = '0;
            ctrl_nxt  = src_ctrl[CTRL_W-1:0];
        end else if (adv) begin
            if ((state == RUN) && !last) begin
                slot_nxt = step_slot;
                ctrl_nxt = step_word;
            end else begin
                state_nxt = IDLE;
                slot_nxt  = '0;
                ctrl_nxt  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            slot   <= '0;
            ctrl_o <= '0;
            len    <= '0;
            for (int k = 0; k < DEPTH; k++)
                sched[k] <= '0;
        end else begin
            state  <= state_nxt;
            slot   <= slot_nxt;
            ctrl_o <= ctrl_nxt;
            if (take) begin
                len <= norm_len;
                for (int k = 0; k < DEPTH; k++)
                    sched[k] <= src_ctrl[k*CTRL_W +: CTRL_W];
            end
        end
    end

    assign slot_o = slot;
    assign last_o = last;
    assign busy_o = (state == RUN);

endmodule
